// File: rtl/data_ram_resp_if.sv
// Request/response bus between a CPU-side master and the data RAM responder.
// Write lanes follow data_sram_wen; read data returns one cycle after the request.
interface data_ram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_ram_resp.sv
// Byte-lane data RAM with a small MMIO window (LED, TIMER, SCRATCH) and a registered read port.
// The TIMER counter is present only when DATA_RAM_TIMER_EN is defined; otherwise offset 0x4 is unmapped.
module data_ram_resp #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [15:0] MMIO_BASE_HI = 16'hbfaf
) (
  input  logic             clk,
  input  logic             reset,
  data_ram_resp_if.slave   bus,
  output logic [15:0]      led
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_ram_q;
  logic [31:0]           r_mmio_q;
  logic                  r_src_mmio;
  logic [15:0]           r_led;
  logic [31:0]           r_scratch;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_is_mmio;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [13:0]           w_off;
  logic                  w_sel_led;
  logic                  w_sel_tmr;
  logic                  w_sel_scr;
  logic [31:0]           w_mask;
  logic [31:0]           w_timer;
  logic                  w_tmr_mapped;
  logic [31:0]           w_mmio_rd;
  logic                  w_unused_addr;

  // Requests seen while reset is high are dropped entirely.
  assign w_req     = bus.data_sram_en & ~reset;
  assign w_wr      = w_req & (|bus.data_sram_wen);
  assign w_rd      = w_req & (bus.data_sram_wen == 4'b0000);
  assign w_is_mmio = (bus.data_sram_addr[31:16] == MMIO_BASE_HI);
  assign w_idx     = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign w_off     = bus.data_sram_addr[15:2];
  assign w_sel_led = (w_off == 14'd0);
  assign w_sel_tmr = (w_off == 14'd1);
  assign w_sel_scr = (w_off == 14'd2);
  assign w_unused_addr = &{1'b0, bus.data_sram_addr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign w_mask[gi*8 +: 8] = {8{bus.data_sram_wen[gi]}};
    end
  endgenerate

  // RAM array and its output register kept reset-free so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr && !w_is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) begin
          r_mem[w_idx][i*8 +: 8] <= bus.data_sram_wdata[i*8 +: 8];
        end
      end
    end
    if (w_rd && !w_is_mmio) begin
      r_ram_q <= r_mem[w_idx];
    end
  end

`ifdef DATA_RAM_TIMER_EN
  logic [31:0] r_timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= 32'h0;
    end else if (w_wr && w_is_mmio && w_sel_tmr) begin
      r_timer <= (r_timer & ~w_mask) | (bus.data_sram_wdata & w_mask);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign w_timer      = r_timer;
  assign w_tmr_mapped = 1'b1;
`else
  assign w_timer      = 32'h0;
  assign w_tmr_mapped = 1'b0;
`endif

  always_comb begin
    w_mmio_rd = 32'h0;
    if (w_sel_led) begin
      w_mmio_rd = {16'h0, r_led};
    end else if (w_sel_tmr && w_tmr_mapped) begin
      w_mmio_rd = w_timer;
    end else if (w_sel_scr) begin
      w_mmio_rd = r_scratch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led      <= 16'h0;
      r_scratch  <= 32'h0;
      r_mmio_q   <= 32'h0;
      r_src_mmio <= 1'b1;
    end else begin
      if (w_wr && w_is_mmio && w_sel_led) begin
        r_led <= (r_led & ~w_mask[15:0]) | (bus.data_sram_wdata[15:0] & w_mask[15:0]);
      end
      if (w_wr && w_is_mmio && w_sel_scr) begin
        r_scratch <= (r_scratch & ~w_mask) | (bus.data_sram_wdata & w_mask);
      end
      // The source flag picks which read register drives rdata; it only moves on reads.
      if (w_rd) begin
        r_src_mmio <= w_is_mmio;
        if (w_is_mmio) begin
          r_mmio_q <= w_mmio_rd;
        end
      end
    end
  end

  assign bus.data_sram_rdata = r_src_mmio ? r_mmio_q : r_ram_q;
  assign led                 = r_led;
endmodule
